// File: rtl/jtframe_sndcmd_pkg.sv
// Shared definitions for the sound-command FIFO: IRQ mode encodings and
// width helpers for the occupancy count and FIFO pointers.
package jtframe_sndcmd_pkg;

  typedef enum int unsigned {
    IRQ_PER_CMD = 0,
    IRQ_LEVEL   = 1
  } irq_mode_e;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // A one-entry FIFO still needs a 1-bit pointer to be a legal vector.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/jtframe_sndcmd_irq.sv
// Sound-CPU interrupt generation: ack rising-edge detect, pending-command
// counter and registered active-low interrupt output.
module jtframe_sndcmd_irq
  import jtframe_sndcmd_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int IRQ_MODE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_empty,
  input  logic i_ack,
  output logic o_int_n
);

  localparam int unsigned CW = cnt_w(DEPTH);

  logic          r_ack_d;
  logic [CW-1:0] r_pend;
  logic          r_int_n;
  logic          w_ack_rise;
  logic          w_inc;
  logic          w_dec;

  assign w_ack_rise = i_ack & ~r_ack_d;
  assign w_inc      = i_push && (r_pend != CW'(DEPTH));
  assign w_dec      = w_ack_rise && (r_pend != '0);
  assign o_int_n    = r_int_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack_d <= 1'b0;
      r_pend  <= '0;
      r_int_n <= 1'b1;
    end else begin
      r_ack_d <= i_ack;
      if (IRQ_MODE == int'(IRQ_LEVEL)) begin
        r_pend  <= '0;
        r_int_n <= i_empty;
      end else begin
        // A push and an ack on the same edge cancel out.
        if (i_push && w_dec) r_pend <= r_pend;
        else if (w_inc)      r_pend <= r_pend + CW'(1);
        else if (w_dec)      r_pend <= r_pend - CW'(1);
        r_int_n <= (r_pend == '0);
      end
    end
  end

endmodule

// File: rtl/jtframe_sndcmd.sv
// Main-to-sound CPU command FIFO with overflow flag and sound-CPU interrupt.
// snd_dout is registered and holds the last popped value once empty.
module jtframe_sndcmd
  import jtframe_sndcmd_pkg::*;
#(
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int OVERWRITE = 0,
  parameter int IRQ_MODE  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      main_we,
  input  logic [DW-1:0]             main_din,
  output logic                      main_full,
  input  logic                      snd_rd,
  output logic [DW-1:0]             snd_dout,
  output logic                      snd_empty,
  output logic [cnt_w(DEPTH)-1:0]   snd_cnt,
  input  logic                      irq_ack,
  output logic                      int_n,
  output logic                      ovf,
  input  logic                      ovf_clr
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_dout;
  logic          r_ovf;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_ovr;
  logic          w_ovr_wr;
  logic          w_mem_we;
  logic [PW-1:0] w_last;
  logic [PW-1:0] w_wr_addr;
  logic [PW-1:0] w_rd_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CW'(DEPTH));
  assign w_pop     = snd_rd & ~w_empty;
  assign w_push    = main_we & (~w_full | w_pop);
  assign w_ovr     = main_we & w_full & ~w_pop;
  assign w_ovr_wr  = w_ovr & (OVERWRITE != 0);
  assign w_mem_we  = w_push | w_ovr_wr;
  assign w_last    = (r_wr == '0) ? PW'(DEPTH - 1) : r_wr - PW'(1);
  assign w_wr_addr = w_ovr_wr ? w_last : r_wr;
  assign w_rd_nxt  = ptr_inc(r_rd);

  assign main_full = w_full;
  assign snd_empty = w_empty;
  assign snd_cnt   = r_cnt;
  assign snd_dout  = r_dout;
  assign ovf       = r_ovf;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_wr_addr] <= main_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_dout <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= w_rd_nxt;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      // The incoming word becomes the head when it lands in an empty slot
      // at the head, or overwrites a lone head entry.
      if ((w_push && (w_empty || (w_pop && r_cnt == CW'(1)))) ||
          (w_ovr_wr && r_cnt == CW'(1)))
        r_dout <= main_din;
      else if (w_pop && r_cnt != CW'(1))
        r_dout <= r_mem[w_rd_nxt];
      if (ovf_clr)    r_ovf <= 1'b0;
      else if (w_ovr) r_ovf <= 1'b1;
    end
  end

  jtframe_sndcmd_irq #(
    .DEPTH    (DEPTH),
    .IRQ_MODE (IRQ_MODE)
  ) u_irq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_mem_we),
    .i_empty (w_empty),
    .i_ack   (irq_ack),
    .o_int_n (int_n)
  );

endmodule
